nios2_computer_nios2_gen2_0_cpu_ocimem_arbiter: RTL
===================================================

// Module: nios2_computer_nios2_gen2_0_cpu_ocimem_arbiter
// PURPOSE
//  Shares the single-port OCI debug RAM between the Avalon debug_mem_slave (CPU side)
//  and JTAG ocimem actions decoded by the debug slave (take_action_ocimem_a/b + jdo).
//  Round-robin arbitration, one access per grant; returns read data on Avalon and in MonDReg.
//  Sits between the debug slave sysclk logic, the Avalon debug port and the debug RAM.
// PARAMETERS
//  ADDR_W      8   RAM word-address width; legal range 4..16
//  JTAG_FIRST  1   priority owner after reset (1 = JTAG, 0 = Avalon)
// PORTS
//  clk                      in   1       system clock, all logic on rising edge
//  reset_n                  in   1       synchronous, active-low reset
//  avl_address              in   ADDR_W  Avalon word address
//  avl_read                 in   1       Avalon read request, held until waitrequest low
//  avl_write                in   1       Avalon write request, held until waitrequest low
//  avl_writedata            in   32      Avalon write data
//  avl_byteenable           in   4       Avalon write byte enables
//  avl_readdata             out  32      read data, valid in the cycle waitrequest is low after a read
//  avl_waitrequest          out  1       low for exactly one cycle per completed Avalon access
//  take_action_ocimem_a     in   1       JTAG: load address (and optionally read), 1-cycle pulse
//  take_action_ocimem_b     in   1       JTAG: write word at current JTAG address, 1-cycle pulse
//  jdo                      in   38      JTAG data: [17+ADDR_W-1:17] addr, [35] read flag, [34:3] wdata
//  MonDReg                  out  32      last JTAG read data
//  jtag_busy                out  1       JTAG request pending or in progress
//  jtag_overrun             out  1       sticky: a JTAG action was dropped
//  ram_addr                 out  ADDR_W  RAM address
//  ram_wdata                out  32      RAM write data
//  ram_be                   out  4       RAM byte enables
//  ram_wren                 out  1       RAM write strobe, 1 cycle
//  ram_rden                 out  1       RAM read strobe, 1 cycle; ram_rdata valid next cycle
//  ram_rdata                in   32      RAM read data, fixed 1-cycle latency
// BEHAVIOUR
//  Reset values: avl_waitrequest=1, avl_readdata=0, MonDReg=0, jtag_busy=0, jtag_overrun=0,
//  ram_wren=0, ram_rden=0, ram_addr=0, ram_wdata=0, ram_be=0. FSM=IDLE, prio=JTAG_FIRST.
//  The JTAG pending request and jtag_addr are discarded/zeroed by reset.
//  JTAG decode (single-entry pending buffer):
//   ocimem_a: jtag_addr<=jdo[17+ADDR_W-1:17]; if jdo[35], pend read.
//   ocimem_b: pend write of jdo[34:3], be=4'hF, at jtag_addr.
//   a and b in the same cycle: a taken, b dropped, overrun set.
//   Any action while jtag_busy: dropped, overrun set. jtag_overrun clears only on reset.
//  FSM: IDLE -> ACC -> (write) DONE | (read) RDWAIT -> DONE -> IDLE.
//   IDLE: request sources are avl_read|avl_write and the JTAG pending buffer.
//         With both requesting, grant goes to the prio side; any grant sets prio to the
//         other side. Grantee address, data and be are captured into registers.
//   ACC: drive ram_addr/ram_wdata/ram_be for one cycle, plus one of ram_wren or ram_rden.
//   RDWAIT: capture ram_rdata.
//   DONE, Avalon grant: avl_waitrequest=0 for this one cycle; avl_readdata is valid for reads.
//   DONE, JTAG grant: MonDReg<=data on reads; clear pending; jtag_addr+=1, wrapping
//        2^ADDR_W-1 -> 0.
//  Latency from IDLE grant cycle T: write completes at T+2, read at T+3.
//   A back-to-back access is granted no earlier than T+3 (write) or T+4 (read).
//  avl_read and avl_write both high: treat as a read.
//  Avalon signals change while waitrequest is high: ignored after capture.
//  Reset mid-access: FSM returns to IDLE next cycle. A RAM write already strobed stays
//   committed; no further strobes.
// TESTING
//  Avl write 0x10<-0xDEADBEEF be=F at T -> ram_wren at T+1, waitrequest low at T+2.
//   Then a read of 0x10 -> readdata 0xDEADBEEF with waitrequest low at T+3.
//  JTAG: ocimem_a addr=0x20, then ocimem_b data=0x12345678 -> RAM[0x20] written,
//   jtag_addr=0x21. Then ocimem_a addr=0x20 with read flag -> MonDReg=0x12345678.
//  After reset (JTAG_FIRST=1), avl write and a JTAG write pend in the same cycle ->
//   JTAG is granted first, Avalon next. Sustained contention alternates grants.
//  JTAG write at addr 0xFF (ADDR_W=8) -> next ocimem_b writes addr 0x00.
//  ocimem_b while jtag_busy=1 -> no extra ram_wren, jtag_overrun=1 until reset.
//  reset_n low during RDWAIT of an avl read -> IDLE next cycle, waitrequest=1,
//   MonDReg=0, no ram_rden after reset.

Source files
------------

// File: rtl/nios2_computer_nios2_gen2_0_cpu_ocimem_arbiter.sv
// Round-robin arbiter sharing the single-port OCI debug RAM between the Avalon
// debug slave and JTAG ocimem actions; one RAM access per grant.
module nios2_computer_nios2_gen2_0_cpu_ocimem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter bit JTAG_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] avl_address,
  input  logic              avl_read,
  input  logic              avl_write,
  input  logic [31:0]       avl_writedata,
  input  logic [3:0]        avl_byteenable,
  output logic [31:0]       avl_readdata,
  output logic              avl_waitrequest,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  output logic [31:0]       MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_be,
  output logic              ram_wren,
  output logic              ram_rden,
  input  logic [31:0]       ram_rdata
);

  // Handshake: avl_read/avl_write are held by the master until avl_waitrequest
  // is sampled low; that low cycle completes the access (readdata valid then).
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_RDWAIT, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic              prio_q, prio_d;          // 1: JTAG wins a tie
  logic              gnt_jtag_q, gnt_jtag_d;
  logic              is_read_q, is_read_d;
  logic [ADDR_W-1:0] acc_addr_q, acc_addr_d;
  logic [31:0]       acc_wdata_q, acc_wdata_d;
  logic [3:0]        acc_be_q, acc_be_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       mon_q, mon_d;
  logic [ADDR_W-1:0] jtag_addr_q, jtag_addr_d;
  logic              jpend_q, jpend_d;
  logic              jpend_rd_q, jpend_rd_d;
  logic [31:0]       jpend_wdata_q, jpend_wdata_d;
  logic              overrun_q, overrun_d;
  logic              req_avl;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};
  assign req_avl    = avl_read | avl_write;

  always_comb begin
    state_d       = state_q;
    prio_d        = prio_q;
    gnt_jtag_d    = gnt_jtag_q;
    is_read_d     = is_read_q;
    acc_addr_d    = acc_addr_q;
    acc_wdata_d   = acc_wdata_q;
    acc_be_d      = acc_be_q;
    rdata_d       = rdata_q;
    mon_d         = mon_q;
    jtag_addr_d   = jtag_addr_q;
    jpend_d       = jpend_q;
    jpend_rd_d    = jpend_rd_q;
    jpend_wdata_d = jpend_wdata_q;
    overrun_d     = overrun_q;

    // The pending buffer holds one request; it stays set until its DONE cycle.
    if (take_action_ocimem_a || take_action_ocimem_b) begin
      if (jpend_q) begin
        overrun_d = 1'b1;
      end else if (take_action_ocimem_a) begin
        jtag_addr_d = jdo[17+ADDR_W-1:17];
        if (jdo[35]) begin
          jpend_d    = 1'b1;
          jpend_rd_d = 1'b1;
        end
        if (take_action_ocimem_b) overrun_d = 1'b1;
      end else begin
        jpend_d       = 1'b1;
        jpend_rd_d    = 1'b0;
        jpend_wdata_d = jdo[34:3];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (req_avl || jpend_q) begin
          gnt_jtag_d = jpend_q && (!req_avl || prio_q);
          prio_d     = !gnt_jtag_d;
          state_d    = S_ACC;
          if (gnt_jtag_d) begin
            is_read_d   = jpend_rd_q;
            acc_addr_d  = jtag_addr_q;
            acc_wdata_d = jpend_wdata_q;
            acc_be_d    = 4'hF;
          end else begin
            is_read_d   = avl_read;
            acc_addr_d  = avl_address;
            acc_wdata_d = avl_writedata;
            acc_be_d    = avl_byteenable;
          end
        end
      end
      S_ACC:    state_d = is_read_q ? S_RDWAIT : S_DONE;
      S_RDWAIT: begin
        rdata_d = ram_rdata;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (gnt_jtag_q) begin
          if (is_read_q) mon_d = rdata_q;
          jpend_d     = 1'b0;
          jtag_addr_d = jtag_addr_q + ADDR_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      prio_q        <= JTAG_FIRST;
      gnt_jtag_q    <= 1'b0;
      is_read_q     <= 1'b0;
      acc_addr_q    <= '0;
      acc_wdata_q   <= '0;
      acc_be_q      <= '0;
      rdata_q       <= '0;
      mon_q         <= '0;
      jtag_addr_q   <= '0;
      jpend_q       <= 1'b0;
      jpend_rd_q    <= 1'b0;
      jpend_wdata_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      gnt_jtag_q    <= gnt_jtag_d;
      is_read_q     <= is_read_d;
      acc_addr_q    <= acc_addr_d;
      acc_wdata_q   <= acc_wdata_d;
      acc_be_q      <= acc_be_d;
      rdata_q       <= rdata_d;
      mon_q         <= mon_d;
      jtag_addr_q   <= jtag_addr_d;
      jpend_q       <= jpend_d;
      jpend_rd_q    <= jpend_rd_d;
      jpend_wdata_q <= jpend_wdata_d;
      overrun_q     <= overrun_d;
    end
  end

  // RAM port is only driven during ACC so idle cycles present a clean zero bus.
  assign ram_wren        = (state_q == S_ACC) && !is_read_q;
  assign ram_rden        = (state_q == S_ACC) && is_read_q;
  assign ram_addr        = (state_q == S_ACC) ? acc_addr_q  : '0;
  assign ram_wdata       = (state_q == S_ACC) ? acc_wdata_q : '0;
  assign ram_be          = (state_q == S_ACC) ? acc_be_q    : '0;
  assign avl_waitrequest = !((state_q == S_DONE) && !gnt_jtag_q);
  assign avl_readdata    = rdata_q;
  assign MonDReg         = mon_q;
  assign jtag_busy       = jpend_q;
  assign jtag_overrun    = overrun_q;

endmodule
